// File: rtl/i2s_rx_pkg.sv
// Shared types and defaults for the I2S slave receiver.
package i2s_rx_pkg;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {ST_DISABLED, ST_SYNC, ST_RUN} rx_state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] left;
    logic [DEF_DATA_W-1:0] right;
  } frame_t;
endpackage

// File: rtl/i2s_rx_fifo.sv
// First-word-fall-through frame FIFO with synchronous flush and level count.
module i2s_rx_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == (AW+1)'(DEPTH));
  assign level_o = r_cnt;
  assign head_o  = empty_o ? '0 : r_mem[r_rptr];

  // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) r_mem[r_wptr] <= push_data_i;
  end
endmodule

// File: rtl/i2s_slave_rx.sv
// I2S (Philips) slave receiver: oversamples SCK/WS/SD, rebuilds stereo frames
// and queues them in a small FWFT FIFO for the register layer.
module i2s_slave_rx
  import i2s_rx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic                          sck_i,
  input  logic                          ws_i,
  input  logic                          sd_i,
  output logic [2*DATA_W-1:0]           rd_data_o,
  output logic                          rd_valid_o,
  input  logic                          rd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  input  logic                          ovf_clr_i,
  output logic                          irq_o
);
  localparam int CW = $clog2(DATA_W+1);

  rx_state_e          r_state;
  logic [2:0]         r_sck_sync;
  logic [1:0]         r_ws_sync, r_sd_sync;
  logic [DATA_W-1:0]  r_sr, r_left_hold, w_sr_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic               r_ws_last, r_left_ok, r_ovf;
  logic               w_rise, w_ws, w_sd, w_word_end, w_push, w_full, w_empty;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync <= '0;
      r_ws_sync  <= '0;
      r_sd_sync  <= '0;
    end else begin
      r_sck_sync <= {r_sck_sync[1:0], sck_i};
      r_ws_sync  <= {r_ws_sync[0], ws_i};
      r_sd_sync  <= {r_sd_sync[0], sd_i};
    end
  end

  assign w_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_ws   = r_ws_sync[1];
  assign w_sd   = r_sd_sync[1];

  // Bits land MSB-first; beyond DATA_W they are dropped, short words stay zero-padded.
  always_comb begin
    w_sr_nxt  = r_sr;
    w_cnt_nxt = r_cnt;
    if (r_cnt < CW'(DATA_W)) begin
      w_sr_nxt  = r_sr | ({w_sd, {(DATA_W-1){1'b0}}} >> r_cnt);
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  assign w_word_end = w_rise && (w_ws != r_ws_last);
  assign w_push     = en_i && (r_state == ST_RUN) && w_word_end && r_ws_last && r_left_ok;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_DISABLED;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_ws_last   <= 1'b0;
      r_left_hold <= '0;
      r_left_ok   <= 1'b0;
    end else if (!en_i) begin
      r_state     <= ST_DISABLED;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_left_hold <= '0;
      r_left_ok   <= 1'b0;
    end else begin
      case (r_state)
        ST_DISABLED: begin
          r_state   <= ST_SYNC;
          r_ws_last <= w_ws;
          r_sr      <= '0;
          r_cnt     <= '0;
        end
        default: begin
          if (w_word_end) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_ws_last <= w_ws;
            if (r_state == ST_SYNC) begin
              // A right->left boundary marks the start of a whole frame.
              if (r_ws_last && !w_ws) r_state <= ST_RUN;
            end else if (!r_ws_last) begin
              r_left_hold <= w_sr_nxt;
              r_left_ok   <= 1'b1;
            end else begin
              r_left_ok   <= 1'b0;
            end
          end else if (w_rise) begin
            r_sr  <= w_sr_nxt;
            r_cnt <= w_cnt_nxt;
          end
        end
      endcase
    end
  end

  i2s_rx_fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .push_i      (w_push),
    .push_data_i ({r_left_hold, w_sr_nxt}),
    .pop_i       (rd_ready_i),
    .head_o      (rd_data_o),
    .level_o     (level_o),
    .full_o      (w_full),
    .empty_o     (w_empty)
  );

  // A flushed push is discarded silently; set beats clear.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                                           r_ovf <= 1'b0;
    else if (w_push && w_full && !rd_ready_i && !flush_i) r_ovf <= 1'b1;
    else if (ovf_clr_i)                                   r_ovf <= 1'b0;
  end

  assign rd_valid_o = !w_empty;
  assign overflow_o = r_ovf;
  assign irq_o      = en_i && rd_valid_o;
endmodule
